fetch_sequencer: RTL and testbench

Fetch/sequence stage of the 4-bit microprocessor, upstream of the instruction ROM and the datapath. It owns the program counter and drives it to the ROM's `ProgramCounter` input. It latches the returned 8-bit instruction into an instruction register and decodes the fields. It then sequences each instruction through FETCH → DECODE → EXECUTE, pulsing the register-file and LED write strobes.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/instruction_decoder.sv | 21 ++
 rtl/fetch_sequencer.sv | 73 +++++++
 tb/tb_fetch_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared instruction-class, ALU-op and sequencer-state encodings
package cpu_pkg;
  localparam logic [1:0] CLS_LOAD  = 2'b00;
  localparam logic [1:0] CLS_STORE = 2'b01;
  localparam logic [1:0] CLS_MOVE  = 2'b10;
  localparam logic [1:0] CLS_ALU   = 2'b11;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;
  typedef enum logic [1:0] {ST_FETCH, ST_DECODE, ST_EXEC, ST_HALT} state_e;
endpackage

// File: rtl/instruction_decoder.sv
// instruction_decoder: splits the IR into datapath fields and strobe qualifiers
module instruction_decoder
  import cpu_pkg::*;
(
  input  logic [7:0] ir_i,
  output logic [1:0] class_o,
  output logic [1:0] dest_o,
  output logic [1:0] src_o,
  output logic [1:0] alu_op_o,
  output logic [3:0] imm_o,
  output logic       reg_wr_o,
  output logic       led_wr_o
);
  assign class_o  = ir_i[7:6];
  assign dest_o   = ir_i[5:4];
  assign src_o    = ir_i[3:2];
  assign alu_op_o = ir_i[1:0];
  assign imm_o    = ir_i[3:0];
  assign led_wr_o = class_o == CLS_STORE;
  assign reg_wr_o = !led_wr_o;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC and IR and steps each instruction through FETCH/DECODE/EXECUTE
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [3:0] PC_RESET      = 4'd1,
  parameter bit         HALT_ON_STORE = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Run,
  input  logic [7:0] Instruction,
  output logic [3:0] ProgramCounter,
  output logic [1:0] Class,
  output logic [1:0] DestSel,
  output logic [1:0] SrcSel,
  output logic [1:0] AluOp,
  output logic [3:0] ImmValue,
  output logic       RegWrite,
  output logic       LedWrite,
  output logic       Halted
);
  state_e     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       reg_wr, led_wr;

  instruction_decoder u_dec (
    .ir_i    (ir_q),
    .class_o (Class),
    .dest_o  (DestSel),
    .src_o   (SrcSel),
    .alu_op_o(AluOp),
    .imm_o   (ImmValue),
    .reg_wr_o(reg_wr),
    .led_wr_o(led_wr)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_FETCH;
      pc_q    <= PC_RESET;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: begin
        ir_d    = Run ? Instruction : ir_q;
        state_d = Run ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        pc_d    = pc_q + 4'd1;
        state_d = (led_wr && HALT_ON_STORE) ? ST_HALT : ST_FETCH;
      end
      default: state_d = ST_HALT;
    endcase
  end

  // Strobes derive only from registered state and IR, so reset clears them at once
  assign RegWrite       = state_q == ST_EXEC && reg_wr;
  assign LedWrite       = state_q == ST_EXEC && led_wr;
  assign Halted         = state_q == ST_HALT;
  assign ProgramCounter = pc_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of reset, a ROM program, decode, Run gating, wrap and abort
module tb_fetch_sequencer;
  logic       clk = 1'b0;
  logic       rst, run, use_rom;
  logic [7:0] instr, instr_man;
  logic [3:0] pc, imm;
  logic [1:0] cls, dst, src, aop;
  logic       rw, lw, hlt;
  logic       rst1, run1;
  logic [3:0] pc1, imm1;
  logic [1:0] cls1, dst1, src1, aop1;
  logic       rw1, lw1, hlt1;
  int         n_tests = 0, n_fail = 0;
  int         nrw, nlw;
  logic [3:0] lw_pc;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [3:0] a);
    case (a)
      4'd1: rom = 8'h05;
      4'd2: rom = 8'h13;
      4'd3: rom = 8'h84;
      4'd4: rom = 8'hC4;
      4'd5: rom = 8'hD8;
      4'd6: rom = 8'h27;
      4'd7: rom = 8'hE3;
      4'd8: rom = 8'h40;
      default: rom = 8'h00;
    endcase
  endfunction

  always_comb instr = use_rom ? rom(pc) : instr_man;

  fetch_sequencer dut (
    .Clock(clk), .Reset(rst), .Run(run), .Instruction(instr),
    .ProgramCounter(pc), .Class(cls), .DestSel(dst), .SrcSel(src), .AluOp(aop),
    .ImmValue(imm), .RegWrite(rw), .LedWrite(lw), .Halted(hlt)
  );

  fetch_sequencer #(.PC_RESET(4'd15), .HALT_ON_STORE(1'b0)) dut_wrap (
    .Clock(clk), .Reset(rst1), .Run(run1), .Instruction(8'b00000001),
    .ProgramCounter(pc1), .Class(cls1), .DestSel(dst1), .SrcSel(src1), .AluOp(aop1),
    .ImmValue(imm1), .RegWrite(rw1), .LedWrite(lw1), .Halted(hlt1)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; use_rom = 1'b1; instr_man = 8'h00;
    rst1 = 1'b1; run1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc", 8'(pc), 8'd1);
    chk("rst_cls", 8'(cls), 8'd0);
    chk("rst_imm", 8'(imm), 8'd0);
    chk("rst_strobes", {6'd0, rw, lw}, 8'd0);
    chk("rst_halt", 8'(hlt), 8'd0);
    chk("rst_wrap_pc", 8'(pc1), 8'd15);
    // program run: instruction k executes on cycle 3k-1, PC advances on cycle 3k
    rst = 1'b0; run = 1'b1; nrw = 0; nlw = 0; lw_pc = 4'd0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      chk($sformatf("run_pc_c%0d", c), 8'(pc), (c >= 24) ? 8'd9 : 8'(1 + c / 3));
      chk($sformatf("run_halt_c%0d", c), 8'(hlt), (c >= 24) ? 8'd1 : 8'd0);
      chk($sformatf("run_excl_c%0d", c), 8'(rw & lw), 8'd0);
      if (rw) nrw++;
      if (lw) begin nlw++; lw_pc = pc; end
    end
    chk("run_regwrite_count", 8'(nrw), 8'd7);
    chk("run_ledwrite_count", 8'(nlw), 8'd1);
    chk("run_ledwrite_pc", 8'(lw_pc), 8'd8);
    // asynchronous reset while halted, observed before any rising edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_pc", 8'(pc), 8'd1);
    chk("arst_halt", 8'(hlt), 8'd0);
    chk("arst_cls", 8'(cls), 8'd0);
    // ALU decode
    use_rom = 1'b0; instr_man = 8'hD8;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("alu_dec_cls", 8'(cls), 8'd3);
    chk("alu_dec_dst", 8'(dst), 8'd1);
    chk("alu_dec_src", 8'(src), 8'd2);
    chk("alu_dec_aop", 8'(aop), 8'd0);
    chk("alu_dec_rw", 8'(rw), 8'd0);
    @(negedge clk);
    chk("alu_exe_rw", 8'(rw), 8'd1);
    chk("alu_exe_lw", 8'(lw), 8'd0);
    @(negedge clk);
    chk("alu_post_rw", 8'(rw), 8'd0);
    chk("alu_post_pc", 8'(pc), 8'd2);
    // Run gating: drop Run in DECODE
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("gate_exe_rw", 8'(rw), 8'd1);
    @(negedge clk);
    chk("gate_pc", 8'(pc), 8'd3);
    instr_man = 8'h40;
    repeat (2) @(negedge clk);
    chk("gate_hold_pc", 8'(pc), 8'd3);
    chk("gate_hold_cls", 8'(cls), 8'd3);
    chk("gate_hold_rw", 8'(rw), 8'd0);
    run = 1'b1;
    @(negedge clk);
    chk("gate_resume_cls", 8'(cls), 8'd1);
    @(negedge clk);
    chk("store_lw", 8'(lw), 8'd1);
    chk("store_rw", 8'(rw), 8'd0);
    @(negedge clk);
    chk("store_halt", 8'(hlt), 8'd1);
    chk("store_pc", 8'(pc), 8'd4);
    @(negedge clk);
    chk("halt_pc_frozen", 8'(pc), 8'd4);
    chk("halt_lw", 8'(lw), 8'd0);
    // reset in the EXECUTE cycle of a LOAD
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; instr_man = 8'h05;
    repeat (3) @(negedge clk);
    chk("abort_pre_pc", 8'(pc), 8'd2);
    repeat (2) @(negedge clk);
    chk("abort_exe_rw", 8'(rw), 8'd1);
    rst = 1'b1;
    #1;
    chk("abort_rw", 8'(rw), 8'd0);
    chk("abort_pc", 8'(pc), 8'd1);
    chk("abort_imm", 8'(imm), 8'd0);
    // PC wrap with HALT_ON_STORE disabled
    @(negedge clk);
    rst1 = 1'b0; run1 = 1'b1;
    @(negedge clk);
    chk("wrap_dec_imm", 8'(imm1), 8'd1);
    @(negedge clk);
    chk("wrap_exe_rw", 8'(rw1), 8'd1);
    chk("wrap_exe_pc", 8'(pc1), 8'd15);
    @(negedge clk);
    chk("wrap_pc", 8'(pc1), 8'd0);
    chk("wrap_halt", 8'(hlt1), 8'd0);
    chk("wrap_rw", 8'(rw1), 8'd0);
    repeat (2) @(negedge clk);
    chk("wrap_second_exe_rw", 8'(rw1), 8'd1);
    @(negedge clk);
    chk("wrap_second_pc", 8'(pc1), 8'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
